// File: rtl/data_memory_pkg.sv
// Shared definitions for the wait-state data memory.
// - funct3 access-type codes, completion error codes, FSM state encoding
// - access_bytes(): number of bytes an access type touches
package data_memory_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TYPE     = 2'b10;
    localparam logic [1:0] ERR_RANGE    = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    // Footprint of an access in bytes; illegal codes report a full word,
    // which never matters because the type error takes priority.
    function automatic logic [2:0] access_bytes(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: access_bytes = 3'd1;
            F3_H, F3_HU: access_bytes = 3'd2;
            default:     access_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_align_unit.sv
// Combinational lane steering for a 32-bit little-endian word.
// Inputs : type_i (funct3), store_i, addr_lo_i (ea[1:0]), store_data_i,
//          rd_word_i (aligned word containing the access)
// Outputs: be_o (byte enables), wr_word_o (data replicated onto its lanes),
//          ld_value_o (extended load result), misaligned_o, illegal_o
module mem_align_unit
    import data_memory_pkg::*;
(
    input  logic [2:0]  type_i,
    input  logic        store_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rd_word_i,
    output logic [3:0]  be_o,
    output logic [31:0] wr_word_o,
    output logic [31:0] ld_value_o,
    output logic        misaligned_o,
    output logic        illegal_o
);

    logic [31:0] rd_shift_s;

    // Decode the access type into lane enables, write data and load extension
    always_comb begin
        be_o         = 4'b0000;
        wr_word_o    = 32'h0000_0000;
        ld_value_o   = 32'h0000_0000;
        misaligned_o = 1'b0;
        illegal_o    = 1'b0;
        // bring the addressed byte/half down to bit 0
        rd_shift_s   = rd_word_i >> {addr_lo_i, 3'b000};
        case (type_i)
            F3_B: begin
                be_o       = 4'b0001 << addr_lo_i;
                wr_word_o  = {4{store_data_i[7:0]}};
                ld_value_o = {{24{rd_shift_s[7]}}, rd_shift_s[7:0]};
            end
            F3_BU: begin
                illegal_o  = store_i;
                be_o       = 4'b0001 << addr_lo_i;
                wr_word_o  = {4{store_data_i[7:0]}};
                ld_value_o = {24'h00_0000, rd_shift_s[7:0]};
            end
            F3_H: begin
                misaligned_o = addr_lo_i[0];
                be_o         = 4'b0011 << addr_lo_i;
                wr_word_o    = {2{store_data_i[15:0]}};
                ld_value_o   = {{16{rd_shift_s[15]}}, rd_shift_s[15:0]};
            end
            F3_HU: begin
                illegal_o    = store_i;
                misaligned_o = addr_lo_i[0];
                be_o         = 4'b0011 << addr_lo_i;
                wr_word_o    = {2{store_data_i[15:0]}};
                ld_value_o   = {16'h0000, rd_shift_s[15:0]};
            end
            F3_W: begin
                misaligned_o = (addr_lo_i != 2'b00);
                be_o         = 4'b1111;
                wr_word_o    = store_data_i;
                ld_value_o   = rd_word_i;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_ws.sv
// Byte-addressed data memory with programmable wait states for the MEM stage.
// Ports: clk, reset (async, active high); req/store/Type/direccion/offset/
//        store_data request side; load_data, busy, done, err, err_code
//        completion side. err/err_code are meaningful only while done=1.
// Memory writes and load_data updates happen only on the edge entering DONE,
// so a reset during the wait phase never leaves a partial write behind.
module data_memory_ws
    import data_memory_pkg::*;
#(
    parameter int TAM     = 4,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        store,
    input  logic [2:0]  Type,
    input  logic [31:0] direccion,
    input  logic [31:0] offset,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int         DEPTH   = 32 * TAM;
    localparam int         AW      = $clog2(DEPTH);
    localparam logic [3:0] LAT_CNT = 4'(LATENCY);

    logic [7:0]  mem_q [0:DEPTH-1];

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] ea_q;
    logic        store_q;
    logic [2:0]  type_q;
    logic [31:0] sdata_q;
    logic [31:0] load_data_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [1:0]  err_code_q;

    logic [31:0]   ea_s;
    logic [32:0]   end_s;
    logic          oor_s;
    logic [AW-1:0] base_s;
    logic [31:0]   rd_word_s;
    logic [3:0]    be_s;
    logic [31:0]   wr_word_s;
    logic [31:0]   ld_value_s;
    logic          misaligned_s;
    logic          illegal_s;
    logic          err_s;
    logic [1:0]    err_code_s;
    logic          complete_s;

    assign ea_s = direccion + offset;

    // The whole footprint must fit: last byte index ea+n-1 < DEPTH
    assign end_s = {1'b0, ea_q} + {30'd0, access_bytes(type_q)};
    assign oor_s = (end_s > 33'(DEPTH));

    // Out-of-range addresses are pinned to word 0 so the read never leaves the array
    assign base_s    = oor_s ? '0 : {ea_q[AW-1:2], 2'b00};
    assign rd_word_s = {mem_q[base_s + AW'(3)], mem_q[base_s + AW'(2)],
                        mem_q[base_s + AW'(1)], mem_q[base_s]};

    assign complete_s = (state_q == WAIT) && (cnt_q == 4'd0);

    mem_align_unit u_align (
        .type_i       (type_q),
        .store_i      (store_q),
        .addr_lo_i    (ea_q[1:0]),
        .store_data_i (sdata_q),
        .rd_word_i    (rd_word_s),
        .be_o         (be_s),
        .wr_word_o    (wr_word_s),
        .ld_value_o   (ld_value_s),
        .misaligned_o (misaligned_s),
        .illegal_o    (illegal_s)
    );

    // Error classification on the latched access, type > range > alignment
    always_comb begin
        err_s      = 1'b0;
        err_code_s = ERR_NONE;
        if (illegal_s) begin
            err_s      = 1'b1;
            err_code_s = ERR_TYPE;
        end else if (oor_s) begin
            err_s      = 1'b1;
            err_code_s = ERR_RANGE;
        end else if (misaligned_s) begin
            err_s      = 1'b1;
            err_code_s = ERR_MISALIGN;
        end else begin
            err_s      = 1'b0;
            err_code_s = ERR_NONE;
        end
    end

    // Byte array: contents survive reset; written only on a clean store completion
    always_ff @(posedge clk) begin
        if (complete_s && store_q && !err_s && !reset) begin
            for (int k = 0; k < 4; k++) begin
                if (be_s[k]) begin
                    mem_q[base_s + AW'(k)] <= wr_word_s[8*k +: 8];
                end
            end
        end
    end

    // Access FSM with wait counter, request latches and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            ea_q        <= 32'h0000_0000;
            store_q     <= 1'b0;
            type_q      <= 3'b000;
            sdata_q     <= 32'h0000_0000;
            load_data_q <= 32'h0000_0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        ea_q    <= ea_s;
                        store_q <= store;
                        type_q  <= Type;
                        sdata_q <= store_data;
                        cnt_q   <= LAT_CNT;
                        busy_q  <= 1'b1;
                        state_q <= WAIT;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        err_q      <= err_s;
                        err_code_q <= err_code_s;
                        if (!err_s && !store_q) begin
                            load_data_q <= ld_value_s;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    err_q      <= 1'b0;
                    err_code_q <= ERR_NONE;
                end
                default: begin
                    state_q    <= IDLE;
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    err_q      <= 1'b0;
                    err_code_q <= ERR_NONE;
                end
            endcase
        end
    end

    assign load_data = load_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_data_memory_ws.sv
// Self-checking bench for data_memory_ws: table of accesses checked through a
// scoreboard queue, plus hand sequences for reset abort, handshake and LATENCY=0.
module tb_data_memory_ws;
    import data_memory_pkg::*;

    localparam int LAT = 2;

    logic        clk;
    logic        reset;
    logic        req;
    logic        req0;
    logic        store;
    logic [2:0]  Type;
    logic [31:0] direccion;
    logic [31:0] offset;
    logic [31:0] store_data;
    logic [31:0] load_data, load0;
    logic        busy, busy0;
    logic        done, done0;
    logic        err, err0;
    logic [1:0]  err_code, code0;

    data_memory_ws #(.TAM(4), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset), .req(req), .store(store), .Type(Type),
        .direccion(direccion), .offset(offset), .store_data(store_data),
        .load_data(load_data), .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    data_memory_ws #(.TAM(4), .LATENCY(0)) u_dut0 (
        .clk(clk), .reset(reset), .req(req0), .store(store), .Type(Type),
        .direccion(direccion), .offset(offset), .store_data(store_data),
        .load_data(load0), .busy(busy0), .done(done0), .err(err0), .err_code(code0)
    );

    typedef struct packed {
        logic        st;
        logic [2:0]  ty;
        logic [31:0] dir;
        logic [31:0] off;
        logic [31:0] sd;
        logic        err;
        logic [1:0]  code;
        logic [31:0] load;
    } vec_t;

    typedef struct {
        int          tag;
        logic        err;
        logic [1:0]  code;
        logic [31:0] load;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h want %h", nm, tag, act, exp);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest pending access
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_done: cycle=%0d got done=1 want 0", cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("done_cycle", e.tag, 32'(cyc), 32'(e.cyc));
                    chk("err", e.tag, {31'd0, err}, {31'd0, e.err});
                    chk("err_code", e.tag, {30'd0, err_code}, {30'd0, e.code});
                    chk("load_data", e.tag, load_data, e.load);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got pending=%0d want 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic drive(input vec_t v);
        req        = 1'b1;
        store      = v.st;
        Type       = v.ty;
        direccion  = v.dir;
        offset     = v.off;
        store_data = v.sd;
    endtask

    task automatic issue(input int tag, input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        drive(v);
        e.tag  = tag;
        e.err  = v.err;
        e.code = v.code;
        e.load = v.load;
        e.cyc  = cyc + LAT + 2;  // accept at next edge, done visible LAT+1 edges later
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        req = 1'b0;
        wait_drain();
    endtask

    vec_t tbl [28];
    vec_t v;
    int   base_cyc;

    initial begin
        tbl[0]  = '{1'b1, F3_W,   32'h0,  32'h0,        32'h4000E081, 1'b0, ERR_NONE,     32'h00000000};
        tbl[1]  = '{1'b0, F3_W,   32'h0,  32'h0,        32'h0,        1'b0, ERR_NONE,     32'h4000E081};
        tbl[2]  = '{1'b1, F3_W,   32'hC,  32'h0,        32'h11223344, 1'b0, ERR_NONE,     32'h4000E081};
        tbl[3]  = '{1'b1, F3_B,   32'h10, 32'hFFFFFFFD, 32'h123456FF, 1'b0, ERR_NONE,     32'h4000E081};
        tbl[4]  = '{1'b0, F3_B,   32'hD,  32'h0,        32'h0,        1'b0, ERR_NONE,     32'hFFFFFFFF};
        tbl[5]  = '{1'b0, F3_BU,  32'hD,  32'h0,        32'h0,        1'b0, ERR_NONE,     32'h000000FF};
        tbl[6]  = '{1'b0, F3_H,   32'hC,  32'h0,        32'h0,        1'b0, ERR_NONE,     32'hFFFFFF44};
        tbl[7]  = '{1'b0, F3_HU,  32'hC,  32'h0,        32'h0,        1'b0, ERR_NONE,     32'h0000FF44};
        tbl[8]  = '{1'b0, F3_W,   32'hC,  32'h0,        32'h0,        1'b0, ERR_NONE,     32'h1122FF44};
        tbl[9]  = '{1'b1, F3_H,   32'hE,  32'h0,        32'h77778001, 1'b0, ERR_NONE,     32'h1122FF44};
        tbl[10] = '{1'b0, F3_H,   32'h8,  32'h6,        32'h0,        1'b0, ERR_NONE,     32'hFFFF8001};
        tbl[11] = '{1'b0, F3_W,   32'hC,  32'h0,        32'h0,        1'b0, ERR_NONE,     32'h8001FF44};
        tbl[12] = '{1'b0, F3_W,   32'h2,  32'h0,        32'h0,        1'b1, ERR_MISALIGN, 32'h8001FF44};
        tbl[13] = '{1'b0, 3'b011, 32'h0,  32'h0,        32'h0,        1'b1, ERR_TYPE,     32'h8001FF44};
        tbl[14] = '{1'b1, F3_W,   32'h70, 32'h10,       32'hFFFFFFFF, 1'b1, ERR_RANGE,    32'h8001FF44};
        tbl[15] = '{1'b1, F3_BU,  32'h0,  32'h0,        32'h000000AA, 1'b1, ERR_TYPE,     32'h8001FF44};
        tbl[16] = '{1'b1, F3_H,   32'h7F, 32'h0,        32'h00001234, 1'b1, ERR_RANGE,    32'h8001FF44};
        tbl[17] = '{1'b1, F3_W,   32'h7C, 32'h0,        32'hCAFEBABE, 1'b0, ERR_NONE,     32'h8001FF44};
        tbl[18] = '{1'b0, F3_W,   32'h7C, 32'h0,        32'h0,        1'b0, ERR_NONE,     32'hCAFEBABE};
        tbl[19] = '{1'b1, 3'b110, 32'h0,  32'h0,        32'h55555555, 1'b1, ERR_TYPE,     32'hCAFEBABE};
        tbl[20] = '{1'b1, F3_W,   32'h2,  32'h0,        32'hDEADBEEF, 1'b1, ERR_MISALIGN, 32'hCAFEBABE};
        tbl[21] = '{1'b0, F3_H,   32'h3,  32'h0,        32'h0,        1'b1, ERR_MISALIGN, 32'hCAFEBABE};
        tbl[22] = '{1'b0, F3_HU,  32'h7F, 32'h0,        32'h0,        1'b1, ERR_RANGE,    32'hCAFEBABE};
        tbl[23] = '{1'b0, F3_BU,  32'h7F, 32'h0,        32'h0,        1'b0, ERR_NONE,     32'h000000CA};
        tbl[24] = '{1'b0, F3_B,   32'h7E, 32'h0,        32'h0,        1'b0, ERR_NONE,     32'hFFFFFFFE};
        tbl[25] = '{1'b0, F3_W,   32'h0,  32'h0,        32'h0,        1'b0, ERR_NONE,     32'h4000E081};
        tbl[26] = '{1'b0, 3'b111, 32'h0,  32'h0,        32'h0,        1'b1, ERR_TYPE,     32'h4000E081};
        tbl[27] = '{1'b1, F3_HU,  32'h4,  32'h0,        32'h0000BEEF, 1'b1, ERR_TYPE,     32'h4000E081};

        req = 1'b0; req0 = 1'b0; store = 1'b0; Type = F3_W;
        direccion = 32'h0; offset = 32'h0; store_data = 32'h0;

        // Asynchronous reset before the first clock edge
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_busy", 0, {31'd0, busy}, 32'd0);
        chk("rst_done", 0, {31'd0, done}, 32'd0);
        chk("rst_err", 0, {31'd0, err}, 32'd0);
        chk("rst_err_code", 0, {30'd0, err_code}, 32'd0);
        chk("rst_load_data", 0, load_data, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 28; i++) begin
            issue(i, tbl[i]);
        end

        // Known content at 0x20, then abort a store to it with a mid-cycle reset
        issue(100, '{1'b1, F3_W, 32'h20, 32'h0, 32'h01020304, 1'b0, ERR_NONE, 32'h4000E081});
        @(posedge clk);
        #1;
        drive('{1'b1, F3_W, 32'h20, 32'h0, 32'h55AA55AA, 1'b0, ERR_NONE, 32'h0});
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy_before", 101, {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", 101, {31'd0, busy}, 32'd0);
        chk("abort_done", 101, {31'd0, done}, 32'd0);
        chk("abort_load_data", 101, load_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        issue(102, '{1'b0, F3_W, 32'h20, 32'h0, 32'h0, 1'b0, ERR_NONE, 32'h01020304});

        // req pulsed while busy must be ignored (exactly one done)
        @(posedge clk);
        #1;
        v = '{1'b0, F3_W, 32'h7C, 32'h0, 32'h0, 1'b0, ERR_NONE, 32'hCAFEBABE};
        drive(v);
        sb_q.push_back('{200, 1'b0, ERR_NONE, 32'hCAFEBABE, cyc + LAT + 2});
        @(posedge clk);
        #1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            chk("busy_window", 200 + i, {31'd0, busy}, (i <= 3) ? 32'd1 : 32'd0);
        end
        req = 1'b0;
        repeat (8) @(negedge clk);
        wait_drain();

        // req held high: one access every LAT+3 edges (DONE, then one IDLE cycle)
        @(posedge clk);
        #1;
        drive('{1'b0, F3_W, 32'h0, 32'h0, 32'h0, 1'b0, ERR_NONE, 32'h0});
        base_cyc = cyc;
        for (int j = 0; j < 3; j++) begin
            sb_q.push_back('{300 + j, 1'b0, ERR_NONE, 32'h4000E081, base_cyc + 1 + j * (LAT + 3) + LAT + 1});
        end
        repeat (15) @(posedge clk);
        #1;
        req = 1'b0;
        repeat (8) @(negedge clk);
        wait_drain();

        // LATENCY=0 instance: done on the edge after the accept edge
        @(posedge clk);
        #1;
        store = 1'b1; Type = F3_W; direccion = 32'h40; offset = 32'h0;
        store_data = 32'hA5A50F0F; req0 = 1'b1;
        @(posedge clk);
        #1;
        req0 = 1'b0;
        chk("lat0_st_busy", 400, {31'd0, busy0}, 32'd1);
        chk("lat0_st_done_early", 400, {31'd0, done0}, 32'd0);
        @(posedge clk);
        #1;
        chk("lat0_st_done", 400, {31'd0, done0}, 32'd1);
        chk("lat0_st_err", 400, {31'd0, err0}, 32'd0);
        @(posedge clk);
        #1;
        chk("lat0_st_done_after", 400, {31'd0, done0}, 32'd0);
        chk("lat0_st_busy_after", 400, {31'd0, busy0}, 32'd0);
        store = 1'b0; req0 = 1'b1;
        @(posedge clk);
        #1;
        req0 = 1'b0;
        chk("lat0_ld_done_early", 401, {31'd0, done0}, 32'd0);
        @(posedge clk);
        #1;
        chk("lat0_ld_done", 401, {31'd0, done0}, 32'd1);
        chk("lat0_ld_data", 401, load0, 32'hA5A50F0F);
        chk("lat0_ld_code", 401, {30'd0, code0}, 32'd0);
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
